imm_gen_arbiter: RTL and testbench

IMM_GEN_ARBITER -- requirements
Module: imm_gen_arbiter

---
 rtl/imm_gen_arbiter.sv | 125 ++++++++++++
 tb/tb_imm_gen_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_arbiter.sv
// rtl/imm_gen_arbiter.sv - two-requester round-robin arbiter feeding one shared RV32I immediate generator
//
// Purpose: two requesters present raw RV32I instructions with an opaque tag.
// One requester is granted per cycle. Its instruction is decoded by a single
// shared immediate extractor. The immediate, the requester index and the tag
// are captured in a one-entry result register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_valid/ready/instr/tag  requester 0 handshake, instruction, tag
//   req1_valid/ready/instr/tag  requester 1 handshake, instruction, tag
//   out_valid/out_ready     result handshake
//   out_imm, out_src, out_tag   generated immediate, granted requester, its tag
module imm_gen_arbiter #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int TAG_W            = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [INSTRUCTION_SIZE-1:0] req0_instr,
  input  logic [TAG_W-1:0]            req0_tag,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [INSTRUCTION_SIZE-1:0] req1_instr,
  input  logic [TAG_W-1:0]            req1_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] out_imm,
  output logic                        out_src,
  output logic [TAG_W-1:0]            out_tag
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [0:0]                  state;
  logic                        rr;
  logic [INSTRUCTION_SIZE-1:0] imm_q;
  logic                        src_q;
  logic [TAG_W-1:0]            tag_q;

  logic                        can_load;
  logic                        any_req;
  logic                        grant;
  logic                        xfer;
  logic [INSTRUCTION_SIZE-1:0] sel_instr;
  logic [INSTRUCTION_SIZE-1:0] imm_d;

  // Grant depends only on the valids and rr, so the readys never see instr/tag.
  // rst_n gates the readys so that no requester is told it was accepted while
  // the register is being held in reset.
  always_comb begin
    can_load   = (state == ST_EMPTY) || out_ready;
    any_req    = req0_valid || req1_valid;
    grant      = (req0_valid && req1_valid) ? rr : req1_valid;
    xfer       = rst_n && can_load && any_req;
    req0_ready = xfer && !grant;
    req1_ready = xfer && grant;
    sel_instr  = grant ? req1_instr : req0_instr;
  end

  // Shared immediate extractor: only the granted instruction is decoded.
  always_comb begin
    imm_d = '0;
    case (sel_instr[6:0])
      OP_LOAD, OP_JALR:
        imm_d = {{20{sel_instr[31]}}, sel_instr[31:20]};
      OP_IMM:
        // slli/srli/srai carry a 5-bit shift amount, not a signed immediate
        if (sel_instr[14:12] == 3'b001 || sel_instr[14:12] == 3'b101)
          imm_d = {27'b0, sel_instr[24:20]};
        else
          imm_d = {{20{sel_instr[31]}}, sel_instr[31:20]};
      OP_STORE:
        imm_d = {{20{sel_instr[31]}}, sel_instr[31:25], sel_instr[11:7]};
      OP_BRANCH:
        imm_d = {{19{sel_instr[31]}}, sel_instr[31], sel_instr[7],
                 sel_instr[30:25], sel_instr[11:8], 1'b0};
      OP_JAL:
        imm_d = {{11{sel_instr[31]}}, sel_instr[31], sel_instr[19:12],
                 sel_instr[20], sel_instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {sel_instr[31:12], 12'b0};
      default:
        imm_d = '0;
    endcase
  end

  // Result stage. A load while FULL with out_ready=1 replaces the result
  // in place, so back-to-back transfers give one result per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      rr    <= 1'b0;
      imm_q <= '0;
      src_q <= 1'b0;
      tag_q <= '0;
    end else if (xfer) begin
      state <= ST_FULL;
      imm_q <= imm_d;
      src_q <= grant;
      tag_q <= grant ? req1_tag : req0_tag;
      rr    <= ~grant;
    end else if (out_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign out_valid = (state == ST_FULL);
  assign out_imm   = imm_q;
  assign out_src   = src_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// tb/tb_imm_gen_arbiter.sv - self-checking bench for imm_gen_arbiter
module tb_imm_gen_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_instr, req1_instr;
  logic [3:0]  req0_tag, req1_tag;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_imm;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  imm_gen_arbiter #(.INSTRUCTION_SIZE(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_src(out_src), .out_tag(out_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          valid;
    bit          rr;
    bit          src;
    bit          loaded;
    logic [31:0] imm;
    logic [3:0]  tag;
  } model_t;

  model_t m, n;
  bit     e_r0, e_r1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value from the ISA field definitions, built with arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int         v;
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h03, 7'h67: v = $signed(ins) >>> 20;
      7'h13:        v = (f3 == 3'd1 || f3 == 3'd5) ? int'(ins[24:20]) : ($signed(ins) >>> 20);
      7'h23:        v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      7'h63:        v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                        + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      7'h6F:        v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                        + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      7'h37, 7'h17: v = ins & 32'hFFFFF000;
      default:      v = 0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m.valid = 0; m.rr = 0; m.src = 0; m.loaded = 0; m.imm = '0; m.tag = '0;
    n = m;
  endtask

  // One clock cycle: commit the previous edge into the model, drive inputs,
  // compare outputs, then work out what the next edge must do.
  task automatic step(input logic rn,
                      input logic a_v, input logic [31:0] a_i, input logic [3:0] a_t,
                      input logic b_v, input logic [31:0] b_i, input logic [3:0] b_t,
                      input logic ordy);
    int g;
    bit can;
    @(negedge clk);
    m = n;
    rst_n = rn;
    req0_valid = a_v; req0_instr = a_i; req0_tag = a_t;
    req1_valid = b_v; req1_instr = b_i; req1_tag = b_t;
    out_ready = ordy;
    if (!rn) model_reset();
    can = !m.valid || ordy;
    if (a_v && b_v) g = int'(m.rr);
    else if (a_v)   g = 0;
    else if (b_v)   g = 1;
    else            g = -1;
    e_r0 = rn && can && (g == 0);
    e_r1 = rn && can && (g == 1);
    #1;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("out_valid", out_valid, m.valid);
    if (m.valid || !m.loaded) begin
      chk("out_imm", out_imm, m.imm);
      chk("out_src", out_src, m.src);
      chk("out_tag", out_tag, m.tag);
    end
    n = m;
    if (rn) begin
      if (e_r0 || e_r1) begin
        n.valid  = 1;
        n.loaded = 1;
        n.imm    = ref_imm(e_r1 ? b_i : a_i);
        n.src    = e_r1;
        n.tag    = e_r1 ? b_t : a_t;
        n.rr     = !e_r1;
      end else if (m.valid && ordy) begin
        n.valid = 0;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, ordy);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    logic [31:0] sw_in  [5];
    logic [31:0] sw_exp [5];
    bit          p0, p1;
    logic [31:0] ri0, ri1;
    logic [3:0]  rt0, rt1;

    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; req0_instr = '0; req1_instr = '0;
    req0_tag = '0; req1_tag = '0; out_ready = 0;
    model_reset();

    // reset state
    step(1'b0, 1'b1, 32'hFFF00093, 4'h3, 1'b1, 32'h0, 4'h1, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_ready0", req0_ready, 1'b0);

    // single requester, addi -1
    step(1'b1, 1'b1, 32'hFFF00093, 4'h3, 1'b0, 32'h0, 4'h0, 1'b1);
    chk("addi_ready0", req0_ready, 1'b1);
    idle(1'b0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_src", out_src, 1'b0);
    chk("addi_tag", out_tag, 4'h3);
    idle(1'b1);

    // round robin from reset
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 32'h00500113, 4'h1, 1'b1, 32'h000012B7, 4'h2, 1'b1);
    chk("rr_first_r0", req0_ready, 1'b1);
    chk("rr_first_r1", req1_ready, 1'b0);
    step(1'b1, 1'b1, 32'h00500113, 4'h1, 1'b1, 32'h000012B7, 4'h2, 1'b1);
    chk("rr_a_imm", out_imm, 32'h00000005);
    chk("rr_second_r1", req1_ready, 1'b1);
    step(1'b1, 1'b1, 32'h00500113, 4'h1, 1'b1, 32'h000012B7, 4'h2, 1'b1);
    chk("rr_b_imm", out_imm, 32'h00001000);
    chk("rr_b_src", out_src, 1'b1);
    chk("rr_third_r0", req0_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // srai held under backpressure
    step(1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'h40515193, 4'h5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 32'h00500113, 4'h1, 1'b1, 32'h40515193, 4'h6, 1'b0);
      chk("hold_imm", out_imm, 32'h00000005);
      chk("hold_tag", out_tag, 4'h5);
      chk("hold_r0", req0_ready, 1'b0);
      chk("hold_r1", req1_ready, 1'b0);
    end
    idle(1'b1);
    chk("release_valid", out_valid, 1'b1);
    idle(1'b1);
    chk("release_empty", out_valid, 1'b0);

    // immediate sweep through requester 1
    sw_in  = '{32'hFE000EE3, 32'hFE000E63, 32'h800000EF, 32'h00112623, 32'h00000033};
    sw_exp = '{32'hFFFFFFFC, 32'hFFFFF7FC, 32'hFFF00000, 32'h0000000C, 32'h00000000};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0, 4'h0, 1'b1, sw_in[k], 4'(k), 1'b1);
      idle(1'b1);
      chk("sweep_imm", out_imm, sw_exp[k]);
    end
    idle(1'b1);

    // asynchronous reset while FULL and stalled
    step(1'b1, 1'b1, 32'hFFF00093, 4'h7, 1'b0, 32'h0, 4'h0, 1'b1);
    idle(1'b0);
    chk("pre_arst_valid", out_valid, 1'b1);
    @(negedge clk);
    m = n;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_imm", out_imm, 32'h0);
    model_reset();
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    idle(1'b1);
    chk("arst_no_result", out_valid, 1'b0);
    step(1'b1, 1'b1, 32'h00500113, 4'h1, 1'b1, 32'h000012B7, 4'h2, 1'b1);
    chk("arst_rr_r0", req0_ready, 1'b1);
    idle(1'b1);

    // randomized traffic with requesters holding until accepted
    p0 = 0; p1 = 0; ri0 = '0; ri1 = '0; rt0 = '0; rt1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1; ri0 = rand_instr(); rt0 = 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1; ri1 = rand_instr(); rt1 = 4'($urandom);
      end
      step(($urandom_range(0, 199) != 0), p0, ri0, rt0, p1, ri1, rt1,
           ($urandom_range(0, 99) < 70));
      if (e_r0) p0 = 0;
      if (e_r1) p1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
